hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// Pipeline sequencer for the fetch->decode->exec front end. Detects load-use hazards against the
//   dec/exec buffer and inserts one bubble. Flushes wrong-path instructions on a taken branch/jump.
//   Sequences the multi-cycle mul/div unit, stalling the front end until it completes.
//   Keeps saturating stall/flush performance counters.
// PARAMETERS
// REG_W      6   register-number width; matches the decode register ports
// MD_LAT     33  mul/div cycles, counted from the start cycle; legal range 2..255
// FLUSH_CYC  2   wrong-path stages killed after a redirect (fetch + decode)
// CNT_W      32  performance-counter width
// PORTS
// i_clk            in   1      clock; every register updates on posedge
// i_rst            in   1      synchronous, active-high reset
// i_dec_valid      in   1      decode holds a real instruction
// i_dec_rs1        in   REG_W  decode rs1 number
// i_dec_rs2        in   REG_W  decode rs2 number
// i_dec_use_rs1    in   1      decode instruction reads rs1
// i_dec_use_rs2    in   1      decode instruction reads rs2
// i_exec_rd        in   REG_W  rd held in the dec/exec buffer
// i_exec_mem_r     in   1      exec instruction is a load
// i_exec_wb        in   1      exec instruction writes back
// i_exec_redirect  in   1      exec resolved a taken branch or jump
// i_exec_md        in   1      exec instruction is MUL*/DIV*/REM*
// o_stall_fetch    out  1      hold the PC and the fetch/dec buffer
// o_stall_dec      out  1      hold the dec/exec buffer inputs and decode state
// o_bubble_exec    out  1      load a NOP into the dec/exec buffer (clear all control bits)
// o_flush          out  1      kill the instructions in fetch and decode
// o_md_busy        out  1      mul/div sequence is in progress
// o_md_done        out  1      one-cycle pulse on the final mul/div cycle; result is valid
// o_stall_cnt      out  CNT_W  saturating count of stall cycles
// o_flush_cnt      out  CNT_W  saturating count of redirect events
// BEHAVIOUR
// - Reset: state=RUN; md_cnt=0; flush_cnt_q=0; both perf counters=0.
//   All 1-bit outputs are 0 during reset and in the cycle after it.
// - FSM states:
//   - RUN: default state.
//   - MD_BUSY: mul/div in progress.
//   - FLUSH: wrong-path kill in progress.
// - Hazard terms:
//   - load_use = i_dec_valid & i_exec_mem_r & i_exec_wb & (i_exec_rd != 0) &
//     ((i_dec_use_rs1 & rs1==rd) | (i_dec_use_rs2 & rs2==rd)).
//   - rd==0 never creates a hazard. Compare all REG_W bits.
// - RUN, priority highest first:
//   - i_exec_redirect: o_flush=1 combinationally; go to FLUSH with flush_cnt_q=FLUSH_CYC-1.
//     A redirect overrides load_use (the stalled instruction is wrong path).
//   - i_exec_md: o_stall_fetch=o_stall_dec=o_md_busy=1; md_cnt=MD_LAT-1; go to MD_BUSY.
//   - load_use: o_stall_fetch=o_stall_dec=o_bubble_exec=1 for exactly 1 cycle; stay in RUN.
//     Next cycle the load has left exec, so the hazard clears by itself.
// - MD_BUSY:
//   - Every cycle: o_stall_fetch=o_stall_dec=o_md_busy=1; md_cnt decrements.
//   - When md_cnt==1: o_md_done=1 and o_md_busy=1; next state is RUN, stalls drop next cycle.
//   - Total stall = MD_LAT cycles, including the start cycle.
//   - i_exec_redirect and load_use are ignored in this state.
// - FLUSH:
//   - o_flush=1 while flush_cnt_q!=0, then decrement; return to RUN when it reaches 0.
//   - A new redirect arriving in FLUSH reloads flush_cnt_q=FLUSH_CYC-1.
//   - Total o_flush width = FLUSH_CYC cycles.
// - Simultaneous i_exec_md & i_exec_redirect is illegal (one exec instruction).
//   Bench asserts it never occurs; RTL resolves it as redirect.
// - Perf counters:
//   - o_stall_cnt += 1 on every cycle with o_stall_fetch=1.
//   - o_flush_cnt += 1 on every RUN->FLUSH transition and every reload.
//   - Both hold at 2^CNT_W-1 (no wrap).
// - Reset mid-operation (MD_BUSY or FLUSH): back to RUN next cycle.
//   o_md_done is not emitted; outputs follow the reset values above.
// - Latency: stall/flush/bubble outputs are combinational from inputs plus state.
//   No i_* to o_* register stage in RUN.
// STRUCTURE
// - Shared package defs.sv gains:
//   - hz_state_t enum {HZ_RUN, HZ_MD_BUSY, HZ_FLUSH}.
//   - REG_ZERO constant.
// - Sub-module sat_counter #(CNT_W) (i_clk, i_rst, i_inc, o_cnt), instantiated twice for the perf counters.
// - Everything else lives in one always_ff (state, md_cnt, flush_cnt_q) plus one always_comb (outputs).
// TESTING
// - Load-use: exec LW rd=5, decode ADD rs1=5 -> 1 cycle with stall_fetch/stall_dec/bubble_exec=1, then 0; stall_cnt=1.
// - No hazard: load rd=0, decode reads x0 -> no stall. Load rd=5, decode use_rs2=0 with rs2=5 -> no stall.
// - Redirect + load_use in the same cycle -> o_flush high exactly 2 cycles, no bubble; flush_cnt=1.
// - MD_LAT=33: i_exec_md pulse -> stalls high 33 cycles; o_md_done only in cycle 33; stall_cnt=33.
// - Reset asserted in MD_BUSY cycle 10 -> all outputs 0 from next cycle; no o_md_done; counters=0.
// - CNT_W=4: 20 load-use stalls -> o_stall_cnt saturates and holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   hz_state_t : sequencer mode (run / mul-div busy / wrong-path flush)
//   MD_CNT_W   : width of the mul/div cycle counter (covers MD_LAT up to 255)
//   REG_ZERO   : register number of the hard-wired zero register
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MD_BUSY = 2'd1,
        HZ_FLUSH   = 2'd2
    } hz_state_t;

    localparam int unsigned MD_CNT_W = 8;
    localparam logic [31:0] REG_ZERO = 32'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_inc        : add one this cycle
//   o_cnt        : current count, holds at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end pipeline sequencer: load-use bubble insertion, wrong-path flush on
// redirect, mul/div stall sequencing, and saturating stall/flush counters.
//   inputs  : decode operand info (i_dec_*), exec-stage info (i_exec_*)
//   outputs : o_stall_fetch, o_stall_dec, o_bubble_exec, o_flush (combinational
//             from inputs + state), o_md_busy, o_md_done, o_stall_cnt, o_flush_cnt
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W     = 6,
    parameter int unsigned MD_LAT    = 33,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dec_valid,
    input  logic [REG_W-1:0] i_dec_rs1,
    input  logic [REG_W-1:0] i_dec_rs2,
    input  logic             i_dec_use_rs1,
    input  logic             i_dec_use_rs2,
    input  logic [REG_W-1:0] i_exec_rd,
    input  logic             i_exec_mem_r,
    input  logic             i_exec_wb,
    input  logic             i_exec_redirect,
    input  logic             i_exec_md,
    output logic             o_stall_fetch,
    output logic             o_stall_dec,
    output logic             o_bubble_exec,
    output logic             o_flush,
    output logic             o_md_busy,
    output logic             o_md_done,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);

    hz_state_t           state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt, md_cnt_d;
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                rst_q;
    logic                load_use;
    logic                flush_evt;

    // Load in exec whose destination is read by decode; x0 never conflicts
    assign load_use = i_dec_valid & i_exec_mem_r & i_exec_wb &
                      (i_exec_rd != REG_W'(REG_ZERO)) &
                      ((i_dec_use_rs1 & (i_dec_rs1 == i_exec_rd)) |
                       (i_dec_use_rs2 & (i_dec_rs2 == i_exec_rd)));

    // State register; rst_q keeps outputs quiet for the cycle after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= HZ_RUN;
            md_cnt      <= '0;
            flush_cnt_q <= '0;
            rst_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            md_cnt      <= md_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rst_q       <= 1'b0;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt;
        flush_cnt_d   = flush_cnt_q;
        o_stall_fetch = 1'b0;
        o_stall_dec   = 1'b0;
        o_bubble_exec = 1'b0;
        o_flush       = 1'b0;
        o_md_busy     = 1'b0;
        o_md_done     = 1'b0;
        flush_evt     = 1'b0;

        if (!i_rst && !rst_q) begin
            case (state_q)
                HZ_RUN: begin
                    // Redirect wins: any stalled decode instruction is wrong path
                    if (i_exec_redirect) begin
                        o_flush   = 1'b1;
                        flush_evt = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_d     = HZ_FLUSH;
                            flush_cnt_d = FC_W'(FLUSH_CYC - 1);
                        end
                    end else if (i_exec_md) begin
                        o_stall_fetch = 1'b1;
                        o_stall_dec   = 1'b1;
                        o_md_busy     = 1'b1;
                        md_cnt_d      = MD_CNT_W'(MD_LAT - 1);
                        state_d       = HZ_MD_BUSY;
                    end else if (load_use) begin
                        o_stall_fetch = 1'b1;
                        o_stall_dec   = 1'b1;
                        o_bubble_exec = 1'b1;
                    end
                end

                HZ_MD_BUSY: begin
                    o_stall_fetch = 1'b1;
                    o_stall_dec   = 1'b1;
                    o_md_busy     = 1'b1;
                    md_cnt_d      = md_cnt - MD_CNT_W'(1);
                    if (md_cnt == MD_CNT_W'(1)) begin
                        o_md_done = 1'b1;
                        state_d   = HZ_RUN;
                    end
                end

                HZ_FLUSH: begin
                    if (i_exec_redirect) begin
                        o_flush     = 1'b1;
                        flush_evt   = 1'b1;
                        flush_cnt_d = FC_W'(FLUSH_CYC - 1);
                    end else if (flush_cnt_q != '0) begin
                        o_flush     = 1'b1;
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                        if (flush_cnt_q == FC_W'(1)) begin
                            state_d = HZ_RUN;
                        end
                    end else begin
                        state_d = HZ_RUN;
                    end
                end

                default: state_d = HZ_RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (o_stall_fetch),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (flush_evt),
        .o_cnt (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a wide-counter instance and a 4-bit
// counter instance share stimulus; a cycle-level behavioural model checks both
// every cycle, and directed scenarios pin literal expectations.
module tb_hazard_ctrl;

    localparam int unsigned REG_W     = 6;
    localparam int unsigned MD_LAT    = 33;
    localparam int unsigned FLUSH_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid, use1, use2, mem_r, wb, redir, md;
    logic [REG_W-1:0] rs1, rs2, rd;

    logic        a_sf, a_sd, a_bub, a_fl, a_busy, a_done;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_sf, b_sd, b_bub, b_fl, b_busy, b_done;
    logic [3:0]  b_scnt, b_fcnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_en  = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(32)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_dec_valid(dec_valid), .i_dec_rs1(rs1), .i_dec_rs2(rs2),
        .i_dec_use_rs1(use1), .i_dec_use_rs2(use2), .i_exec_rd(rd), .i_exec_mem_r(mem_r),
        .i_exec_wb(wb), .i_exec_redirect(redir), .i_exec_md(md),
        .o_stall_fetch(a_sf), .o_stall_dec(a_sd), .o_bubble_exec(a_bub), .o_flush(a_fl),
        .o_md_busy(a_busy), .o_md_done(a_done), .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt)
    );

    hazard_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_dec_valid(dec_valid), .i_dec_rs1(rs1), .i_dec_rs2(rs2),
        .i_dec_use_rs1(use1), .i_dec_use_rs2(use2), .i_exec_rd(rd), .i_exec_mem_r(mem_r),
        .i_exec_wb(wb), .i_exec_redirect(redir), .i_exec_md(md),
        .o_stall_fetch(b_sf), .o_stall_dec(b_sd), .o_bubble_exec(b_bub), .o_flush(b_fl),
        .o_md_busy(b_busy), .o_md_done(b_done), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_md_left = 0;   // mul/div cycles still owed after this one
    int          m_fl_left = 0;   // flush cycles still owed after this one
    bit          m_rst_prev = 1'b1;
    longint      m_sc_a = 0, m_fc_a = 0;
    int          m_sc_b = 0, m_fc_b = 0;

    always @(negedge clk) begin
        if (run_en) begin
            bit lu, e_stall, e_bub, e_fl, e_busy, e_done, e_fev;
            assert (!(md && redir)) else $error("illegal stimulus: md and redirect together");
            lu = dec_valid && mem_r && wb && (rd != 0) &&
                 ((use1 && rs1 == rd) || (use2 && rs2 == rd));
            {e_stall, e_bub, e_fl, e_busy, e_done, e_fev} = '0;
            if (rst) begin
                m_md_left = 0;
                m_fl_left = 0;
            end else if (m_rst_prev) begin
                // quiet cycle right after reset
            end else if (m_md_left > 0) begin
                e_stall = 1; e_busy = 1; e_done = (m_md_left == 1);
                m_md_left--;
            end else if (m_fl_left > 0) begin
                e_fl = 1;
                if (redir) begin m_fl_left = FLUSH_CYC - 1; e_fev = 1; end
                else m_fl_left--;
            end else if (redir) begin
                e_fl = 1; e_fev = 1; m_fl_left = FLUSH_CYC - 1;
            end else if (md) begin
                e_stall = 1; e_busy = 1; m_md_left = MD_LAT - 1;
            end else if (lu) begin
                e_stall = 1; e_bub = 1;
            end

            chk("stall_fetch", a_sf, e_stall);
            chk("stall_dec", a_sd, e_stall);
            chk("bubble", a_bub, e_bub);
            chk("flush", a_fl, e_fl);
            chk("md_busy", a_busy, e_busy);
            chk("md_done", a_done, e_done);
            chk("b_outs", {b_sf, b_sd, b_bub, b_fl, b_busy, b_done},
                {e_stall, e_stall, e_bub, e_fl, e_busy, e_done});
            if (!rst) begin
                chk("stall_cnt_a", a_scnt, m_sc_a);
                chk("flush_cnt_a", a_fcnt, m_fc_a);
                chk("stall_cnt_b", b_scnt, m_sc_b);
                chk("flush_cnt_b", b_fcnt, m_fc_b);
            end

            if (rst) begin
                m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
            end else begin
                if (e_stall) begin
                    if (m_sc_a < 64'hFFFF_FFFF) m_sc_a++;
                    if (m_sc_b < 15) m_sc_b++;
                end
                if (e_fev) begin
                    if (m_fc_a < 64'hFFFF_FFFF) m_fc_a++;
                    if (m_fc_b < 15) m_fc_b++;
                end
            end
            m_rst_prev = rst;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        dec_valid = 0; use1 = 0; use2 = 0; mem_r = 0; wb = 0; redir = 0; md = 0;
        rs1 = '0; rs2 = '0; rd = '0;
    endtask

    task automatic set_load_use();
        idle_in();
        dec_valid = 1; use1 = 1; rs1 = 6'd5; rs2 = 6'd3; rd = 6'd5; mem_r = 1; wb = 1;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        int st_n, done_n, done_at;
        bit any_done;
        rst = 1; idle_in();
        run_en = 1'b1;
        next_cyc(); next_cyc();

        // cycle right after reset: hazard present but outputs must stay 0
        rst = 0; set_load_use();
        @(negedge clk); chk("post_rst_quiet", {a_sf, a_bub}, 2'b00);
        next_cyc();

        // load-use bubble, one cycle only
        @(negedge clk);
        chk("lu_stall", {a_sf, a_sd, a_bub}, 3'b111);
        next_cyc(); idle_in();
        @(negedge clk);
        chk("lu_clear", a_sf, 1'b0);
        chk("lu_cnt", a_scnt, 32'd1);
        next_cyc();

        // no hazard: load to x0 read by decode
        idle_in(); dec_valid = 1; use1 = 1; rs1 = 0; rd = 0; mem_r = 1; wb = 1;
        @(negedge clk); chk("x0_nohaz", a_sf, 1'b0);
        next_cyc();
        // no hazard: matching rs2 but not used
        idle_in(); dec_valid = 1; use2 = 0; rs2 = 6'd5; rd = 6'd5; mem_r = 1; wb = 1;
        @(negedge clk); chk("rs2_unused", a_sf, 1'b0);
        next_cyc();

        // redirect overrides load-use
        set_load_use(); redir = 1;
        @(negedge clk); chk("redir_c1", {a_fl, a_bub, a_sf}, 3'b100);
        next_cyc(); idle_in();
        @(negedge clk); chk("redir_c2", a_fl, 1'b1);
        next_cyc();
        @(negedge clk); chk("redir_c3", a_fl, 1'b0); chk("redir_cnt", a_fcnt, 32'd1);
        next_cyc();

        // mul/div sequence
        idle_in(); md = 1;
        st_n = 0; done_n = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (a_sf) st_n++;
            if (a_done) begin done_n++; done_at = k; end
            next_cyc(); md = 0;
        end
        chk("md_stall_len", st_n, 33);
        chk("md_done_at", done_at, 33);
        chk("md_done_n", done_n, 1);
        chk("md_stall_cnt", a_scnt, 32'd34);
        chk("md_stall_cnt_sat", b_scnt, 4'd15);

        // reset in mul/div cycle 10
        any_done = 0;
        for (int k = 1; k <= 10; k++) begin
            md = (k == 1); rst = (k == 10);
            @(negedge clk); if (a_done) any_done = 1;
            next_cyc();
        end
        rst = 0; md = 0;
        @(negedge clk);
        chk("rst_md_outs", {a_sf, a_sd, a_bub, a_fl, a_busy, a_done}, 6'd0);
        chk("rst_md_cnts", {a_scnt, a_fcnt}, 64'd0);
        next_cyc();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); if (a_done) any_done = 1;
            next_cyc();
        end
        chk("rst_md_nodone", any_done, 1'b0);

        // 20 load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_load_use(); next_cyc();
            idle_in();      next_cyc();
        end
        @(negedge clk);
        chk("sat_b", b_scnt, 4'd15);
        chk("sat_a", a_scnt, 32'd20);
        next_cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            redir     = ($urandom_range(0, 11) == 0);
            md        = !redir && ($urandom_range(0, 39) == 0);
            dec_valid = $urandom_range(0, 1);
            use1      = $urandom_range(0, 1);
            use2      = $urandom_range(0, 1);
            mem_r     = $urandom_range(0, 1);
            wb        = $urandom_range(0, 1);
            rs1       = REG_W'($urandom_range(0, 3));
            rs2       = REG_W'($urandom_range(0, 3));
            rd        = REG_W'($urandom_range(0, 3));
            next_cyc();
        end

        run_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
